ahb_sram_ctrl: RTL and testbench

AHB_SRAM_CTRL -- requirements
Module: ahb_sram_ctrl

---
 rtl/ahb_sram_ctrl.sv | 137 +++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave bridging a byte-addressed window onto a single-port synchronous SRAM.
// Programmable wait states; malformed transfers get a two-cycle ERROR response.
module ahb_sram_ctrl #(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP,
  output logic        sram_cen,
  output logic        sram_wen,
  output logic [3:0]  sram_ben,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout
);

  localparam int unsigned CNT_W = $clog2(WAIT_STATES + 2);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(WAIT_STATES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q;
  logic [2:0]       size_q;

  logic       accept_c;
  logic       err_c;
  logic [3:0] lanes_c;
  logic       unused_htrans_c;

  assign unused_htrans_c = HTRANS[0];

  // Data-phase completion: reads always need one extra cycle for the SRAM latency.
  always_comb begin
    HREADY = 1'b1;
    case (state)
      S_WR:    HREADY = (cnt == WR_LAST);
      S_RD:    HREADY = (cnt == RD_LAST);
      S_ERR1:  HREADY = 1'b0;
      default: HREADY = 1'b1;
    endcase
  end

  // Address-phase decode and error classification.
  always_comb begin
    accept_c = HSEL & HTRANS[1] & HREADY;
    err_c    = 1'b0;
    if (HSIZE > 3'd2)                               err_c = 1'b1;
    if ((HADDR >> ADDR_W) != 32'd0)                 err_c = 1'b1;
    if ((HSIZE == 3'd1) && HADDR[0])                err_c = 1'b1;
    if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))   err_c = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      addr_q <= 32'd0;
      size_q <= 3'd0;
    end else begin
      if (accept_c) begin
        addr_q <= HADDR;
        size_q <= HSIZE;
      end
      if (HREADY) begin
        cnt <= '0;
        if (!accept_c)  state <= S_IDLE;
        else if (err_c) state <= S_ERR1;
        else if (HWRITE) state <= S_WR;
        else            state <= S_RD;
      end else if (state == S_ERR1) begin
        state <= S_ERR2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Active-low byte lanes for the registered write size/offset.
  always_comb begin
    case (size_q)
      3'd0:    lanes_c = ~(4'b0001 << addr_q[1:0]);
      3'd1:    lanes_c = addr_q[1] ? 4'b0011 : 4'b1100;
      default: lanes_c = 4'h0;
    endcase
  end

  always_comb begin
    HRDATA    = 32'd0;
    HRESP     = 2'd0;
    sram_cen  = 1'b1;
    sram_wen  = 1'b1;
    sram_ben  = 4'hF;
    sram_addr = 32'd0;
    sram_din  = 32'd0;
    case (state)
      S_WR: begin
        sram_addr = {addr_q[31:2], 2'b00};
        if (HREADY) begin
          sram_cen = 1'b0;
          sram_wen = 1'b0;
          sram_ben = lanes_c;
          sram_din = HWDATA;
        end
      end
      S_RD: begin
        sram_addr = {addr_q[31:2], 2'b00};
        if (HREADY) begin
          HRDATA = sram_dout;
        end else begin
          sram_cen = 1'b0;
          sram_ben = 4'h0;
        end
      end
      S_ERR1, S_ERR2: HRESP = 2'd1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Scoreboard bench for ahb_sram_ctrl: instance 0 runs with two wait states, instance 1 with none.
// A byte-level reference memory predicts every response; a separate monitor checks each data phase.
module tb_ahb_sram_ctrl;

  localparam int NI     = 2;
  localparam int K_IDLE = 0;
  localparam int K_WR   = 1;
  localparam int K_RD   = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int          kind;
    int          lows;
    logic [3:0]  ben;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        hsel   [NI];
  logic [31:0] haddr  [NI];
  logic [1:0]  htrans [NI];
  logic        hwrite [NI];
  logic [2:0]  hsize  [NI];
  logic [31:0] hwdata [NI];
  logic [31:0] hrdata [NI];
  logic        hready [NI];
  logic [1:0]  hresp  [NI];
  logic        cen    [NI];
  logic        wen    [NI];
  logic [3:0]  ben    [NI];
  logic [31:0] saddr  [NI];
  logic [31:0] sdin   [NI];
  logic [31:0] sdout  [NI];

  exp_t        sb      [NI][$];
  bit   [7:0]  ref_mem [NI][512];
  bit   [31:0] mem     [NI][128];
  logic [31:0] pend_wd [NI];

  int   lows   [NI];
  int   cen_lo [NI];
  bit   resp_bad [NI];
  bit   zero_bad [NI];
  bit   rd_bad   [NI];
  exp_t mon_e;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ahb_sram_ctrl #(.ADDR_W(24), .WAIT_STATES(2)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HRDATA(hrdata[0]),
    .HREADY(hready[0]), .HRESP(hresp[0]), .sram_cen(cen[0]), .sram_wen(wen[0]),
    .sram_ben(ben[0]), .sram_addr(saddr[0]), .sram_din(sdin[0]), .sram_dout(sdout[0])
  );

  ahb_sram_ctrl #(.ADDR_W(24), .WAIT_STATES(0)) u_dut1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HRDATA(hrdata[1]),
    .HREADY(hready[1]), .HRESP(hresp[1]), .sram_cen(cen[1]), .sram_wen(wen[1]),
    .sram_ben(ben[1]), .sram_addr(saddr[1]), .sram_din(sdin[1]), .sram_dout(sdout[1])
  );

  function automatic int ws(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference model: plain byte-array semantics of an AHB slave over SRAM.
  function automatic exp_t model(input int d, input logic sel, input logic [1:0] tr, input logic wr,
                                 input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   nb;
    int   base;
    e.kind = K_IDLE; e.lows = 0; e.ben = 4'hF; e.addr = 32'd0; e.data = 32'd0;
    if (!(sel && tr[1])) return e;
    nb = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
    if (sz > 3'd2 || a >= 32'h0100_0000 || (int'(a[1:0]) % nb) != 0) begin
      e.kind = K_ERR; e.lows = 1;
      return e;
    end
    base   = int'(a[8:0]) & ~3;
    e.addr = 32'(base);
    if (wr) begin
      e.kind = K_WR; e.lows = ws(d); e.data = wd;
      for (int i = 0; i < nb; i++) begin
        int ln;
        ln = (int'(a[1:0]) + i) % 4;
        e.ben[ln] = 1'b0;
        ref_mem[d][base + ln] = wd[8*ln +: 8];
      end
    end else begin
      e.kind = K_RD; e.lows = ws(d) + 1;
      for (int i = 0; i < 4; i++) e.data[8*i +: 8] = ref_mem[d][base + i];
    end
    return e;
  endfunction

  // SRAM device: one-cycle read latency, byte-lane writes.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (!cen[g] && !wen[g]) begin
        logic [31:0] w;
        w = mem[g][saddr[g][8:2]];
        for (int b = 0; b < 4; b++) if (!ben[g][b]) w[8*b +: 8] = sdin[g][8*b +: 8];
        mem[g][saddr[g][8:2]] <= w;
      end else if (!cen[g]) begin
        sdout[g] <= mem[g][saddr[g][8:2]];
      end
    end
  end

  // Monitor: follows each data phase and scores it against the queued expectation.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (!rst_n) begin
        sb[g].delete();
        lows[g] = 0; cen_lo[g] = 0; resp_bad[g] = 0; zero_bad[g] = 0; rd_bad[g] = 0;
      end else if (sb[g].size() != 0) begin
        mon_e = sb[g][0];
        if (!hready[g]) begin
          lows[g]++;
          if (!cen[g]) cen_lo[g]++;
          if (hresp[g] != ((mon_e.kind == K_ERR) ? 2'd1 : 2'd0)) resp_bad[g] = 1;
          if (hrdata[g] != 32'd0) zero_bad[g] = 1;
          if (mon_e.kind == K_RD && (cen[g] || !wen[g] || ben[g] != 4'h0 || saddr[g] != mon_e.addr))
            rd_bad[g] = 1;
        end else begin
          chk($sformatf("i%0d_wait_cycles", g), 32'(lows[g]), 32'(mon_e.lows));
          chk($sformatf("i%0d_hresp", g), 32'(hresp[g]), (mon_e.kind == K_ERR) ? 32'd1 : 32'd0);
          chk($sformatf("i%0d_hresp_wait", g), 32'(resp_bad[g]), 32'd0);
          chk($sformatf("i%0d_hrdata_wait", g), 32'(zero_bad[g]), 32'd0);
          case (mon_e.kind)
            K_WR: begin
              chk($sformatf("i%0d_wr_early_cen", g), 32'(cen_lo[g]), 32'd0);
              chk($sformatf("i%0d_wr_cen_wen", g), 32'({cen[g], wen[g]}), 32'd0);
              chk($sformatf("i%0d_wr_ben", g), 32'(ben[g]), 32'(mon_e.ben));
              chk($sformatf("i%0d_wr_addr", g), saddr[g], mon_e.addr);
              chk($sformatf("i%0d_wr_din", g), sdin[g], mon_e.data);
              chk($sformatf("i%0d_wr_hrdata", g), hrdata[g], 32'd0);
            end
            K_RD: begin
              chk($sformatf("i%0d_rd_cen_cycles", g), 32'(cen_lo[g]), 32'(mon_e.lows));
              chk($sformatf("i%0d_rd_ctl", g), 32'(rd_bad[g]), 32'd0);
              chk($sformatf("i%0d_rd_final_cen", g), 32'(cen[g]), 32'd1);
              chk($sformatf("i%0d_rd_data", g), hrdata[g], mon_e.data);
            end
            default: begin
              chk($sformatf("i%0d_sram_touch", g), 32'(cen_lo[g] + (cen[g] ? 0 : 1)), 32'd0);
              chk($sformatf("i%0d_hrdata", g), hrdata[g], 32'd0);
            end
          endcase
          void'(sb[g].pop_front());
          lows[g] = 0; cen_lo[g] = 0; resp_bad[g] = 0; zero_bad[g] = 0; rd_bad[g] = 0;
        end
      end
    end
  end

  // One address phase; its data phase overlaps the next call (write data follows one beat later).
  task automatic xfer(input int d, input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    bit r;
    int n;
    hsel[d] = sel; htrans[d] = tr; haddr[d] = a; hwrite[d] = wr; hsize[d] = sz;
    hwdata[d] = pend_wd[d];
    n = 0;
    do begin
      @(negedge clk);
      r = hready[d];
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 40);
    if (!r) begin
      n_vec++; n_fail++;
      $display("FAIL i%0d_handshake: hready low for %0d cycles, required high within 40", d, n);
    end
    sb[d].push_back(model(d, sel, tr, wr, sz, a, wd));
    pend_wd[d] = wd;
  endtask

  task automatic idle(input int d);
    xfer(d, 1'b0, 2'b00, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  task automatic check_reset_outs(input int d, input string tag);
    chk($sformatf("%s_i%0d_hready", tag, d), 32'(hready[d]), 32'd1);
    chk($sformatf("%s_i%0d_hresp", tag, d), 32'(hresp[d]), 32'd0);
    chk($sformatf("%s_i%0d_hrdata", tag, d), hrdata[d], 32'd0);
    chk($sformatf("%s_i%0d_cen_wen", tag, d), 32'({cen[d], wen[d]}), 32'd3);
    chk($sformatf("%s_i%0d_ben", tag, d), 32'(ben[d]), 32'hF);
    chk($sformatf("%s_i%0d_addr", tag, d), saddr[d], 32'd0);
    chk($sformatf("%s_i%0d_din", tag, d), sdin[d], 32'd0);
  endtask

  task automatic random_run(input int d, input int count);
    logic       sel;
    logic [1:0] tr;
    logic       wr;
    logic [2:0] sz;
    logic [31:0] a;
    for (int k = 0; k < count; k++) begin
      sel = ($urandom_range(0, 9) != 0);
      tr  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) tr[1] = 1'b1;
      wr  = 1'($urandom);
      sz  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a   = ($urandom_range(0, 15) == 0) ? 32'h0100_0000 + 32'($urandom) % 32'h00FF_0000
                                         : 32'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 3'd1) a[0] = 1'b0;
        if (sz == 3'd2) a[1:0] = 2'b00;
      end
      xfer(d, sel, tr, wr, sz, a, 32'($urandom));
    end
    idle(d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < NI; d++) begin
      hsel[d] = 1'b0; htrans[d] = 2'b00; haddr[d] = 32'd0; hwrite[d] = 1'b0;
      hsize[d] = 3'd0; hwdata[d] = 32'd0; pend_wd[d] = 32'd0;
    end
    rst_n = 1'b0;
    #12;
    check_reset_outs(0, "por");
    check_reset_outs(1, "por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Two wait states: word write/read, byte merge, then each error class.
    xfer(0, 1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF);
    xfer(0, 1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0100, 32'd0);
    xfer(0, 1'b1, 2'b10, 1'b1, 3'd0, 32'h0000_0103, 32'hAA00_0000);
    xfer(0, 1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0100, 32'd0);
    xfer(0, 1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0102, 32'd0);
    xfer(0, 1'b1, 2'b10, 1'b1, 3'd1, 32'h0000_0101, 32'h1234_5678);
    xfer(0, 1'b1, 2'b10, 1'b0, 3'd3, 32'h0000_0100, 32'd0);
    xfer(0, 1'b1, 2'b10, 1'b1, 3'd2, 32'h0100_0000, 32'hCAFE_F00D);
    xfer(0, 1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0100, 32'd0);
    idle(0);
    random_run(0, 150);

    // Zero wait states: back-to-back write then read of the same word.
    xfer(1, 1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0010, 32'h5A5A_0F0F);
    xfer(1, 1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0010, 32'd0);
    idle(1);
    random_run(1, 150);

    // Reset in the middle of a read wait cycle, then a normal read.
    xfer(0, 1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0100, 32'd0);
    hsel[0] = 1'b0; htrans[0] = 2'b00;
    @(negedge clk);
    chk("rst_pre_hready", 32'(hready[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_outs(0, "rst_mid");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    xfer(0, 1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0100, 32'd0);
    xfer(0, 1'b1, 2'b10, 1'b1, 3'd1, 32'h0000_0102, 32'h7788_0000);
    xfer(0, 1'b1, 2'b11, 1'b0, 3'd2, 32'h0000_0100, 32'd0);
    idle(0);

    repeat (3) @(posedge clk);
    #1;
    chk("drain_i0", 32'(sb[0].size()), 32'd0);
    chk("drain_i1", 32'(sb[1].size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
